// File: rtl/id_exe_reg.sv
// ID->EXE pipeline register for the 5-stage ARM core.
// Captures decoded control, operand values and the shifter operand from ID at
// every rising clk edge. Priority at each edge is rst > flush > freeze > load.
// A flush or an id_valid=0 load produces a bubble: control fields read as 0 and
// valid_out is 0, so downstream stages never act on a squashed instruction.
// Optional feature: define FORWARDING_EN to add the src1/src2 index registers
// used by the forwarding unit.
module id_exe_reg #(
  parameter int REG_LEN = 32,
  parameter int CMD_LEN = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               flush,
  input  logic               id_valid,
  input  logic [REG_LEN-1:0] pc_in,
  input  logic [REG_LEN-1:0] val_rn_in,
  input  logic [REG_LEN-1:0] val_rm_in,
  input  logic [11:0]        shift_op_in,
  input  logic               imm_in,
  input  logic [23:0]        signed_imm_in,
  input  logic [CMD_LEN-1:0] exe_cmd_in,
  input  logic               wb_en_in,
  input  logic               mem_r_en_in,
  input  logic               mem_w_en_in,
  input  logic               b_in,
  input  logic               s_in,
  input  logic [3:0]         dest_in,
  input  logic [3:0]         sr_in,
`ifdef FORWARDING_EN
  input  logic [3:0]         src1_in,
  input  logic [3:0]         src2_in,
  output logic [3:0]         src1_out,
  output logic [3:0]         src2_out,
`endif
  output logic [REG_LEN-1:0] pc_out,
  output logic [REG_LEN-1:0] val_rn_out,
  output logic [REG_LEN-1:0] val_rm_out,
  output logic [11:0]        shift_op_out,
  output logic               imm_out,
  output logic [23:0]        signed_imm_out,
  output logic [CMD_LEN-1:0] exe_cmd_out,
  output logic               wb_en_out,
  output logic               mem_r_en_out,
  output logic               mem_w_en_out,
  output logic               b_out,
  output logic               s_out,
  output logic [3:0]         dest_out,
  output logic [3:0]         sr_out,
  output logic               is_mem_cmd_out,
  output logic               valid_out
);

  // Control values to load: forced to 0 when ID holds a bubble.
  logic               imm_s;
  logic [CMD_LEN-1:0] exe_cmd_s;
  logic               wb_en_s;
  logic               mem_r_en_s;
  logic               mem_w_en_s;
  logic               b_s;
  logic               s_s;
  logic               is_mem_cmd_s;
`ifdef FORWARDING_EN
  logic [3:0]         src1_s;
  logic [3:0]         src2_s;
`endif

  // Gate control fields with id_valid so a bubble can never write back or touch memory.
  always_comb begin
    imm_s        = 1'b0;
    exe_cmd_s    = {CMD_LEN{1'b0}};
    wb_en_s      = 1'b0;
    mem_r_en_s   = 1'b0;
    mem_w_en_s   = 1'b0;
    b_s          = 1'b0;
    s_s          = 1'b0;
    is_mem_cmd_s = 1'b0;
`ifdef FORWARDING_EN
    src1_s       = 4'd0;
    src2_s       = 4'd0;
`endif
    if (id_valid) begin
      imm_s        = imm_in;
      exe_cmd_s    = exe_cmd_in;
      wb_en_s      = wb_en_in;
      mem_r_en_s   = mem_r_en_in;
      mem_w_en_s   = mem_w_en_in;
      b_s          = b_in;
      s_s          = s_in;
      is_mem_cmd_s = mem_r_en_in | mem_w_en_in;
`ifdef FORWARDING_EN
      src1_s       = src1_in;
      src2_s       = src2_in;
`endif
    end else begin
      imm_s        = 1'b0;
      exe_cmd_s    = {CMD_LEN{1'b0}};
      wb_en_s      = 1'b0;
      mem_r_en_s   = 1'b0;
      mem_w_en_s   = 1'b0;
      b_s          = 1'b0;
      s_s          = 1'b0;
      is_mem_cmd_s = 1'b0;
`ifdef FORWARDING_EN
      src1_s       = 4'd0;
      src2_s       = 4'd0;
`endif
    end
  end

  // Pipeline register: reset and flush clear everything, freeze holds, otherwise load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      pc_out         <= {REG_LEN{1'b0}};
      val_rn_out     <= {REG_LEN{1'b0}};
      val_rm_out     <= {REG_LEN{1'b0}};
      shift_op_out   <= 12'd0;
      imm_out        <= 1'b0;
      signed_imm_out <= 24'd0;
      exe_cmd_out    <= {CMD_LEN{1'b0}};
      wb_en_out      <= 1'b0;
      mem_r_en_out   <= 1'b0;
      mem_w_en_out   <= 1'b0;
      b_out          <= 1'b0;
      s_out          <= 1'b0;
      dest_out       <= 4'd0;
      sr_out         <= 4'd0;
      is_mem_cmd_out <= 1'b0;
      valid_out      <= 1'b0;
`ifdef FORWARDING_EN
      src1_out       <= 4'd0;
      src2_out       <= 4'd0;
`endif
    end else if (!freeze) begin
      pc_out         <= pc_in;
      val_rn_out     <= val_rn_in;
      val_rm_out     <= val_rm_in;
      shift_op_out   <= shift_op_in;
      imm_out        <= imm_s;
      signed_imm_out <= signed_imm_in;
      exe_cmd_out    <= exe_cmd_s;
      wb_en_out      <= wb_en_s;
      mem_r_en_out   <= mem_r_en_s;
      mem_w_en_out   <= mem_w_en_s;
      b_out          <= b_s;
      s_out          <= s_s;
      dest_out       <= dest_in;
      sr_out         <= sr_in;
      is_mem_cmd_out <= is_mem_cmd_s;
      valid_out      <= id_valid;
`ifdef FORWARDING_EN
      src1_out       <= src1_s;
      src2_out       <= src2_s;
`endif
    end else begin
      // Stall: every register keeps its value, valid_out included.
      valid_out      <= valid_out;
    end
  end

endmodule
